// File: rtl/div_sched_ctrl.sv
// Programmable tick divider controller: owns the divide counter, runs/idles on enable,
// and swaps in new divide ratios only at a period boundary.
module div_sched_ctrl #(
  parameter int unsigned CNT_W       = 28,
  parameter int unsigned DEFAULT_DIV = 50000000,
  parameter int unsigned MIN_DIV     = 2
) (
  input  logic             clk_in,
  input  logic             clear,
  input  logic             enable,
  input  logic             cfg_valid,
  input  logic [CNT_W-1:0] cfg_div,
  output logic             cfg_ready,
  output logic             tick,
  output logic             clk_div,
  output logic             running,
  output logic [CNT_W-1:0] div_active,
  output logic [15:0]      tick_count
);

  localparam logic [CNT_W-1:0] DefDiv = CNT_W'(DEFAULT_DIV);
  localparam logic [CNT_W-1:0] MinDiv = CNT_W'(MIN_DIV);

  typedef enum logic [1:0] {StIdle, StRun, StPend} state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [CNT_W-1:0]   div_q, div_d;
  logic [CNT_W-1:0]   pend_q, pend_d;
  logic               tick_q, tick_d;
  logic               clk_div_q, clk_div_d;
  logic               running_q, running_d;
  logic               ready_q, ready_d;
  logic [15:0]        tick_count_q, tick_count_d;

  logic               xfer;
  logic               terminal;
  logic [CNT_W-1:0]   clamped;

  assign xfer     = cfg_valid & ready_q;
  assign clamped  = (cfg_div < MinDiv) ? MinDiv : cfg_div;
  assign terminal = (count_q == div_q - CNT_W'(1));

  always_comb begin
    state_d      = state_q;
    count_d      = count_q;
    div_d        = div_q;
    pend_d       = pend_q;
    tick_d       = 1'b0;
    clk_div_d    = clk_div_q;
    ready_d      = ready_q;
    tick_count_d = tick_count_q;

    // Counting and tick generation are identical in RUN and PEND.
    if (state_q != StIdle) begin
      if (terminal) begin
        count_d      = '0;
        tick_d       = 1'b1;
        clk_div_d    = ~clk_div_q;
        tick_count_d = tick_count_q + 16'd1;
      end else begin
        count_d = count_q + CNT_W'(1);
      end
    end

    unique case (state_q)
      StIdle: begin
        count_d = '0;
        ready_d = 1'b1;
        if (xfer) div_d = clamped;
        if (enable) state_d = StRun;
      end
      StRun: begin
        if (xfer && enable) begin
          pend_d  = clamped;
          state_d = StPend;
          ready_d = 1'b0;
        end else if (xfer) begin
          div_d = clamped;
        end
        if (!enable) begin
          state_d = StIdle;
          count_d = '0;
        end
      end
      StPend: begin
        // Pending ratio lands at the period boundary, or at once when stopping.
        if (terminal || !enable) begin
          div_d   = pend_q;
          state_d = StRun;
          ready_d = 1'b1;
        end
        if (!enable) begin
          state_d = StIdle;
          count_d = '0;
        end
      end
      default: begin
        state_d = StIdle;
        count_d = '0;
        ready_d = 1'b1;
      end
    endcase

    running_d = (state_d != StIdle);
  end

  always_ff @(posedge clk_in or posedge clear) begin
    if (clear) begin
      state_q      <= StIdle;
      count_q      <= '0;
      div_q        <= DefDiv;
      pend_q       <= '0;
      tick_q       <= 1'b0;
      clk_div_q    <= 1'b1;
      running_q    <= 1'b0;
      ready_q      <= 1'b1;
      tick_count_q <= '0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      div_q        <= div_d;
      pend_q       <= pend_d;
      tick_q       <= tick_d;
      clk_div_q    <= clk_div_d;
      running_q    <= running_d;
      ready_q      <= ready_d;
      tick_count_q <= tick_count_d;
    end
  end

  assign cfg_ready  = ready_q;
  assign tick       = tick_q;
  assign clk_div    = clk_div_q;
  assign running    = running_q;
  assign div_active = div_q;
  assign tick_count = tick_count_q;

endmodule

// File: tb/tb_div_sched_ctrl.sv
// Directed bench for div_sched_ctrl: expected ticks are queued ahead of time and checked as they
// appear; a second instance with ratio 1 exercises tick_count wrap.
module tb_div_sched_ctrl;

  localparam int unsigned CNT_W = 28;

  logic             clk_in = 1'b0;
  logic             clear, enable, cfg_valid;
  logic [CNT_W-1:0] cfg_div;
  logic             cfg_ready, tick, clk_div, running;
  logic [CNT_W-1:0] div_active;
  logic [15:0]      tick_count;

  logic             clear2, enable2, cfg_valid2;
  logic [CNT_W-1:0] cfg_div2;
  logic             cfg_ready2, tick2, clk_div2, running2;
  logic [CNT_W-1:0] div_active2;
  logic [15:0]      tick_count2;

  div_sched_ctrl #(.CNT_W(CNT_W), .DEFAULT_DIV(4), .MIN_DIV(2)) dut (
    .clk_in(clk_in), .clear(clear), .enable(enable), .cfg_valid(cfg_valid), .cfg_div(cfg_div),
    .cfg_ready(cfg_ready), .tick(tick), .clk_div(clk_div), .running(running),
    .div_active(div_active), .tick_count(tick_count)
  );

  div_sched_ctrl #(.CNT_W(CNT_W), .DEFAULT_DIV(1), .MIN_DIV(1)) dut_wrap (
    .clk_in(clk_in), .clear(clear2), .enable(enable2), .cfg_valid(cfg_valid2), .cfg_div(cfg_div2),
    .cfg_ready(cfg_ready2), .tick(tick2), .clk_div(clk_div2), .running(running2),
    .div_active(div_active2), .tick_count(tick_count2)
  );

  always #5 clk_in = ~clk_in;

  int cyc = 0;
  always @(posedge clk_in) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    logic [15:0] tc;
    logic        clk;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic push_tick(input int c, input logic [15:0] tc, input logic clk);
    exp_t e;
    e.cyc = c;
    e.tc  = tc;
    e.clk = clk;
    exp_q.push_back(e);
  endtask

  // Advance one cycle and score any tick (or missing tick) on the main instance.
  task automatic step();
    exp_t e;
    @(negedge clk_in);
    if (tick === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("spurious_tick", 32'(tick), 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("tick_cycle", 32'(cyc), 32'(e.cyc));
        chk("tick_count", 32'(tick_count), 32'(e.tc));
        chk("clk_div", 32'(clk_div), 32'(e.clk));
      end
    end else if (exp_q.size() != 0 && exp_q[0].cyc <= cyc) begin
      e = exp_q.pop_front();
      chk("tick_missing", 32'(tick), 32'd1);
    end
  endtask

  task automatic wait_until(input int target);
    while (cyc < target) step();
  endtask

  int s, t0, t2, t3;

  initial begin
    clear = 1'b1; enable = 1'b0; cfg_valid = 1'b0; cfg_div = '0;
    clear2 = 1'b1; enable2 = 1'b0; cfg_valid2 = 1'b0; cfg_div2 = '0;
    step();
    chk("rst_tick", 32'(tick), 32'd0);
    chk("rst_clk_div", 32'(clk_div), 32'd1);
    chk("rst_running", 32'(running), 32'd0);
    chk("rst_div_active", 32'(div_active), 32'd4);
    chk("rst_tick_count", 32'(tick_count), 32'd0);
    chk("rst_cfg_ready", 32'(cfg_ready), 32'd1);

    clear = 1'b0; clear2 = 1'b0; enable2 = 1'b1; s = cyc;
    step(); step();
    chk("idle_running", 32'(running), 32'd0);

    // Default ratio 4: tick every 4 cycles, clk_div period 8.
    t0 = cyc; enable = 1'b1;
    push_tick(t0 + 5, 16'd1, 1'b0);
    push_tick(t0 + 9, 16'd2, 1'b1);
    push_tick(t0 + 13, 16'd3, 1'b0);
    push_tick(t0 + 17, 16'd4, 1'b1);
    step();
    chk("run_running", 32'(running), 32'd1);

    // Ratio 10 offered at count 1; old period finishes first.
    wait_until(t0 + 18);
    chk("run_cfg_ready", 32'(cfg_ready), 32'd1);
    cfg_valid = 1'b1; cfg_div = 28'd10;
    step();
    chk("pend_cfg_ready", 32'(cfg_ready), 32'd0);
    chk("pend_div_active", 32'(div_active), 32'd4);
    cfg_valid = 1'b0;
    push_tick(t0 + 21, 16'd5, 1'b0);
    push_tick(t0 + 31, 16'd6, 1'b1);
    push_tick(t0 + 41, 16'd7, 1'b0);
    wait_until(t0 + 21);
    chk("switch_div_active", 32'(div_active), 32'd10);
    chk("switch_cfg_ready", 32'(cfg_ready), 32'd1);

    // PEND with ratio 7, then drop enable: ratio applied immediately, outputs frozen.
    wait_until(t0 + 42);
    cfg_valid = 1'b1; cfg_div = 28'd7;
    step();
    chk("pend2_cfg_ready", 32'(cfg_ready), 32'd0);
    cfg_valid = 1'b0; enable = 1'b0;
    step();
    chk("stop_running", 32'(running), 32'd0);
    chk("stop_div_active", 32'(div_active), 32'd7);
    chk("stop_cfg_ready", 32'(cfg_ready), 32'd1);
    repeat (12) step();
    chk("hold_tick_count", 32'(tick_count), 32'd7);
    chk("hold_clk_div", 32'(clk_div), 32'd0);

    // Ratio 0 in IDLE clamps to 2.
    cfg_valid = 1'b1; cfg_div = '0;
    step();
    chk("clamp_div_active", 32'(div_active), 32'd2);
    cfg_valid = 1'b0;
    t2 = cyc; enable = 1'b1;
    push_tick(t2 + 3, 16'd8, 1'b1);
    push_tick(t2 + 5, 16'd9, 1'b0);
    push_tick(t2 + 7, 16'd10, 1'b1);
    wait_until(t2 + 7);

    // Queue ratio 9, then clear between edges: pending ratio must be lost.
    cfg_valid = 1'b1; cfg_div = 28'd9;
    step();
    chk("pend3_cfg_ready", 32'(cfg_ready), 32'd0);
    cfg_valid = 1'b0;
    #2 clear = 1'b1;
    #1;
    chk("clr_running", 32'(running), 32'd0);
    chk("clr_tick", 32'(tick), 32'd0);
    chk("clr_div_active", 32'(div_active), 32'd4);
    chk("clr_tick_count", 32'(tick_count), 32'd0);
    chk("clr_clk_div", 32'(clk_div), 32'd1);
    chk("clr_cfg_ready", 32'(cfg_ready), 32'd1);
    step();
    clear = 1'b0; t3 = cyc;
    push_tick(t3 + 5, 16'd1, 1'b0);
    push_tick(t3 + 9, 16'd2, 1'b1);
    push_tick(t3 + 13, 16'd3, 1'b0);
    wait_until(t3 + 13);
    chk("post_clr_div_active", 32'(div_active), 32'd4);
    enable = 1'b0;

    // Wrap instance ticks every cycle: count k is visible at cycle s+1+k.
    wait_until(s + 65536);
    chk("wrap_pre_count", 32'(tick_count2), 32'hFFFF);
    chk("wrap_pre_clk_div", 32'(clk_div2), 32'd0);
    step();
    chk("wrap_count", 32'(tick_count2), 32'h0000);
    chk("wrap_clk_div", 32'(clk_div2), 32'd1);
    chk("wrap_tick", 32'(tick2), 32'd1);
    chk("wrap_running", 32'(running2), 32'd1);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
